// File: rtl/regs_wb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regs_wb_ctrl_pkg
//   Shared definitions for the integer register file write-back controller:
//   polarity constants, register file geometry, write-port grant encoding
//   and a small saturating-counter helper.
// ---------------------------------------------------------------------------
package regs_wb_ctrl_pkg;

    // Polarity of reset and write enables throughout the write-back slice.
    localparam logic RST_ACTIVE = 1'b1;
    localparam logic WEN_ACTIVE = 1'b1;

    // Register file geometry.
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_NUM    = 32;

    // x0 is hard-wired to zero and can never be waited on.
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // Owner of the register file write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_EX   = 2'd1,
        GNT_LL   = 2'd2
    } grant_e;

    // Increment a 4-bit counter, holding it at lim once reached.
    function automatic logic [3:0] sat_inc4(input logic [3:0] val,
                                            input logic [3:0] lim);
        if (val >= lim) begin
            return lim;
        end
        return val + 4'd1;
    endfunction

endpackage

// File: rtl/regs_wb_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// regs_scoreboard
//   Busy vector for registers awaiting a long-latency (LL) result, and the
//   decode hazard compare against the instruction sitting in ID.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   set_en/addr    ID issued an LL op writing set_addr (x0 ignored)
//   clr_en/addr    LL result for clr_addr is written back this cycle
//   rs1, rs2, rd   operand and destination of the instruction in ID
//   hazard         ID must stall (RAW on rs1/rs2 or WAW on rd)
// ---------------------------------------------------------------------------
module regs_scoreboard
    import regs_wb_ctrl_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    output logic              hazard
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] busy_vis;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && (set_addr != ZERO_REG)) begin
            set_mask[set_addr] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_addr] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle re-issue keeps the register
    // busy for the newer op; bit 0 is forced low so x0 never waits.
    always_comb begin
        busy_nxt    = (busy & ~clr_mask) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // A register being written back this cycle is forwarded by the register
    // file, so it is already safe to read and must not stall ID.
    assign busy_vis = busy & ~clr_mask;

    assign hazard = ((rs1 != ZERO_REG) && busy_vis[rs1]) ||
                    ((rs2 != ZERO_REG) && busy_vis[rs2]) ||
                    ((rd  != ZERO_REG) && busy_vis[rd]);

endmodule

// File: rtl/regs_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regs_wb_ctrl
//   Write-back controller for the 32-entry integer register file. Shares the
//   single write port between the single-cycle EX path and the long-latency
//   (LL: load/divide) path, guards LL against starvation by stalling EX, and
//   raises a decode hazard for registers with an outstanding LL result.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   ex_wen_i/waddr/wdata   EX write request (held while ex_stall_o is high)
//   ex_stall_o             EX must hold its request this cycle
//   ll_valid_i/waddr/wdata LL result (held until accepted)
//   ll_ready_o             LL result accepted this cycle
//   id_issue_i/issue_rd_i  ID issues an LL op writing issue_rd
//   id_rs1/rs2/rd_i        registers used by the instruction in ID
//   id_hazard_o            ID must stall
//   rf_wen/waddr/wdata_o   register file write port
// ---------------------------------------------------------------------------
module regs_wb_ctrl
    import regs_wb_ctrl_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W,
    parameter int NUM_REGS = REG_NUM,
    parameter int MAX_WAIT = 3            // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_wen_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    output logic              ex_stall_o,
    input  logic              ll_valid_i,
    input  logic [ADDR_W-1:0] ll_waddr_i,
    input  logic [DATA_W-1:0] ll_wdata_i,
    output logic              ll_ready_o,
    input  logic              id_issue_i,
    input  logic [ADDR_W-1:0] id_issue_rd_i,
    input  logic [ADDR_W-1:0] id_rs1_i,
    input  logic [ADDR_W-1:0] id_rs2_i,
    input  logic [ADDR_W-1:0] id_rd_i,
    output logic              id_hazard_o,
    output logic              rf_wen_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o
);

    localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    logic [3:0] wait_cnt;
    logic       starve;
    grant_e     gnt;
    logic       ll_hs;
    logic       ll_refused;

    // Grant is same-cycle: the register file bypasses writes to its read
    // ports, so there is no benefit in registering the arbitration result.
    // EX wins by default; once LL has been refused MAX_WAIT times in a row
    // the starve flag hands the port to LL and holds EX off.
    always_comb begin
        gnt = GNT_NONE;
        if (starve) begin
            if (ll_valid_i) begin
                gnt = GNT_LL;
            end
        end else if (ex_wen_i == WEN_ACTIVE) begin
            gnt = GNT_EX;
        end else if (ll_valid_i) begin
            gnt = GNT_LL;
        end
    end

    assign ll_ready_o = (gnt == GNT_LL);
    assign ll_hs      = ll_valid_i & ll_ready_o;
    assign ll_refused = ll_valid_i & ~ll_ready_o;
    assign ex_stall_o = starve;

    // Idle port drives zeros rather than stale data.
    always_comb begin
        rf_wen_o   = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        case (gnt)
            GNT_EX: begin
                rf_wen_o   = WEN_ACTIVE;
                rf_waddr_o = ex_waddr_i;
                rf_wdata_o = ex_wdata_i;
            end
            GNT_LL: begin
                rf_wen_o   = WEN_ACTIVE;
                rf_waddr_o = ll_waddr_i;
                rf_wdata_o = ll_wdata_i;
            end
            default: begin
                rf_wen_o   = 1'b0;
            end
        endcase
    end

    // Starvation tracking. While starve is high LL can no longer be refused,
    // so the flag simply holds until the LL handshake releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            wait_cnt <= '0;
            starve   <= 1'b0;
        end else if (ll_hs) begin
            wait_cnt <= '0;
            starve   <= 1'b0;
        end else if (ll_refused) begin
            wait_cnt <= sat_inc4(wait_cnt, WAIT_MAX);
            if (wait_cnt == WAIT_LAST) begin
                starve <= 1'b1;
            end
        end
    end

    regs_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (id_issue_i),
        .set_addr (id_issue_rd_i),
        .clr_en   (ll_hs),
        .clr_addr (ll_waddr_i),
        .rs1      (id_rs1_i),
        .rs2      (id_rs2_i),
        .rd       (id_rd_i),
        .hazard   (id_hazard_o)
    );

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regs_wb_ctrl
//   Self-checking bench for regs_wb_ctrl: directed scenarios followed by
//   randomized traffic, all compared against a behavioural model that keeps
//   a per-register busy table and a count of consecutive LL refusals.
// ---------------------------------------------------------------------------
module tb_regs_wb_ctrl;

    localparam int MAXW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_wen_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_stall_o;
    logic        ll_valid_i;
    logic [4:0]  ll_waddr_i;
    logic [31:0] ll_wdata_i;
    logic        ll_ready_o;
    logic        id_issue_i;
    logic [4:0]  id_issue_rd_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic [4:0]  id_rd_i;
    logic        id_hazard_o;
    logic        rf_wen_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    regs_wb_ctrl #(
        .ADDR_W   (5),
        .DATA_W   (32),
        .NUM_REGS (32),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_wen_i      (ex_wen_i),
        .ex_waddr_i    (ex_waddr_i),
        .ex_wdata_i    (ex_wdata_i),
        .ex_stall_o    (ex_stall_o),
        .ll_valid_i    (ll_valid_i),
        .ll_waddr_i    (ll_waddr_i),
        .ll_wdata_i    (ll_wdata_i),
        .ll_ready_o    (ll_ready_o),
        .id_issue_i    (id_issue_i),
        .id_issue_rd_i (id_issue_rd_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_hazard_o   (id_hazard_o),
        .rf_wen_o      (rf_wen_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: which registers await an LL result, and how many cycles
    // in a row the current LL result has been turned away.
    bit busy_m[32];
    int refusals;
    bit ex_hold;
    bit ll_hold;

    // Values seen at the last sampled negedge, for directed checks.
    logic        o_stall, o_ready, o_haz, o_wen;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [3:0]  o_wait;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        refusals = 0;
        ex_hold  = 1'b0;
        ll_hold  = 1'b0;
    endtask

    task automatic clear_inputs();
        ex_wen_i      = 1'b0;
        ex_waddr_i    = '0;
        ex_wdata_i    = '0;
        ll_valid_i    = 1'b0;
        ll_waddr_i    = '0;
        ll_wdata_i    = '0;
        id_issue_i    = 1'b0;
        id_issue_rd_i = '0;
        id_rs1_i      = '0;
        id_rs2_i      = '0;
        id_rd_i       = '0;
    endtask

    function automatic logic [31:0] busy_packed();
        logic [31:0] v;
        v = '0;
        foreach (busy_m[i]) v[i] = busy_m[i];
        return v;
    endfunction

    function automatic bit reg_waits(input logic [4:0] r, input bit hs,
                                     input logic [4:0] hs_addr);
        return (r != 5'd0) && busy_m[r] && !(hs && (hs_addr == r));
    endfunction

    // One clock: check every output against the model at the negedge, then
    // advance the model on the following posedge with the same inputs.
    task automatic run_cycle();
        bit          e_stall, e_ready, e_wen, e_haz;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        int          e_wait;
        @(negedge clk);
        e_stall = (refusals >= MAXW);
        e_ready = ll_valid_i && (e_stall || !ex_wen_i);
        e_wen   = 1'b0;
        e_waddr = '0;
        e_wdata = '0;
        if (!e_stall && ex_wen_i) begin
            e_wen = 1'b1; e_waddr = ex_waddr_i; e_wdata = ex_wdata_i;
        end else if (e_ready) begin
            e_wen = 1'b1; e_waddr = ll_waddr_i; e_wdata = ll_wdata_i;
        end
        e_haz  = reg_waits(id_rs1_i, e_ready, ll_waddr_i) ||
                 reg_waits(id_rs2_i, e_ready, ll_waddr_i) ||
                 reg_waits(id_rd_i,  e_ready, ll_waddr_i);
        e_wait = (refusals > MAXW) ? MAXW : refusals;

        o_stall = ex_stall_o;
        o_ready = ll_ready_o;
        o_haz   = id_hazard_o;
        o_wen   = rf_wen_o;
        o_waddr = rf_waddr_o;
        o_wdata = rf_wdata_o;
        o_wait  = dut.wait_cnt;

        chk("ex_stall",  32'(o_stall), 32'(e_stall));
        chk("ll_ready",  32'(o_ready), 32'(e_ready));
        chk("rf_wen",    32'(o_wen),   32'(e_wen));
        chk("rf_waddr",  32'(o_waddr), 32'(e_waddr));
        chk("rf_wdata",  o_wdata,      e_wdata);
        chk("id_hazard", 32'(o_haz),   32'(e_haz));
        chk("wait_cnt",  32'(o_wait),  32'(e_wait));

        @(posedge clk);
        if (e_ready) begin
            refusals = 0;
            busy_m[ll_waddr_i] = 1'b0;
        end else if (ll_valid_i && refusals < 1000) begin
            refusals++;
        end
        if (id_issue_i && id_issue_rd_i != 5'd0) busy_m[id_issue_rd_i] = 1'b1;
        ex_hold = e_stall && ex_wen_i;
        ll_hold = ll_valid_i && !e_ready;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();

        // Reset held with traffic present: nothing may accumulate.
        ex_wen_i = 1'b1; ex_waddr_i = 5'd1;
        ll_valid_i = 1'b1; ll_waddr_i = 5'd3;
        id_issue_i = 1'b1; id_issue_rd_i = 5'd4;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(ex_stall_o), 32'd0);
        chk("rst_wait",  32'(dut.wait_cnt), 32'd0);
        chk("rst_busy",  dut.u_sb.busy, 32'd0);
        clear_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
        run_cycle();
        chk("idle_wen", 32'(o_wen), 32'd0);
        chk("idle_ready", 32'(o_ready), 32'd0);

        // EX and LL collide: EX first, LL the next cycle.
        ex_wen_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h11;
        ll_valid_i = 1'b1; ll_waddr_i = 5'd6; ll_wdata_i = 32'h22;
        run_cycle();
        chk("col_waddr", 32'(o_waddr), 32'd5);
        chk("col_ready", 32'(o_ready), 32'd0);
        ex_wen_i = 1'b0;
        run_cycle();
        chk("col2_waddr", 32'(o_waddr), 32'd6);
        chk("col2_wdata", o_wdata, 32'h22);
        chk("col2_ready", 32'(o_ready), 32'd1);
        clear_inputs();

        // Continuous EX starves LL for MAX_WAIT cycles, then EX stalls once.
        ex_wen_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'hA5A5;
        ll_valid_i = 1'b1; ll_waddr_i = 5'd3; ll_wdata_i = 32'h33;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) ll_valid_i = 1'b0;
            run_cycle();
            chk($sformatf("starve_stall_c%0d", c), 32'(o_stall), 32'(c == 4));
            if (c == 4) begin
                chk("starve_ll_wr", 32'(o_waddr), 32'd3);
                chk("starve_ready", 32'(o_ready), 32'd1);
            end
            if (c == 5) chk("starve_wait_clr", 32'(o_wait), 32'd0);
        end
        clear_inputs();

        // RAW hazard on x7 until its LL result is written back.
        id_issue_i = 1'b1; id_issue_rd_i = 5'd7;
        run_cycle();
        id_issue_i = 1'b0; id_rs1_i = 5'd7;
        run_cycle();
        chk("raw_haz1", 32'(o_haz), 32'd1);
        run_cycle();
        chk("raw_haz2", 32'(o_haz), 32'd1);
        ll_valid_i = 1'b1; ll_waddr_i = 5'd7; ll_wdata_i = 32'h77;
        run_cycle();
        chk("raw_hs_haz", 32'(o_haz), 32'd0);
        chk("raw_hs_data", o_wdata, 32'h77);
        ll_valid_i = 1'b0;
        run_cycle();
        chk("raw_after_haz", 32'(o_haz), 32'd0);
        clear_inputs();

        // Re-issue of x9 in the cycle its previous result retires.
        id_issue_i = 1'b1; id_issue_rd_i = 5'd9;
        run_cycle();
        ll_valid_i = 1'b1; ll_waddr_i = 5'd9; ll_wdata_i = 32'h99;
        run_cycle();
        clear_inputs();
        id_rd_i = 5'd9;
        run_cycle();
        chk("reissue_haz", 32'(o_haz), 32'd1);
        chk("reissue_busy9", 32'(dut.u_sb.busy[9]), 32'd1);
        clear_inputs();
        ll_valid_i = 1'b1; ll_waddr_i = 5'd9;
        run_cycle();
        clear_inputs();

        // x0 is never tracked.
        id_issue_i = 1'b1; id_issue_rd_i = 5'd0;
        run_cycle();
        clear_inputs();
        run_cycle();
        chk("x0_haz", 32'(o_haz), 32'd0);
        chk("x0_busy", dut.u_sb.busy, 32'd0);

        // Randomized traffic under the EX/LL hold rules.
        for (int n = 0; n < 3000; n++) begin
            if (!ex_hold) begin
                ex_wen_i   = ($urandom_range(99) < 55);
                ex_waddr_i = 5'($urandom_range(7));
                ex_wdata_i = $urandom;
            end
            if (!ll_hold) begin
                ll_valid_i = ($urandom_range(99) < 45);
                ll_waddr_i = 5'($urandom_range(7));
                ll_wdata_i = $urandom;
            end
            id_issue_i    = ($urandom_range(99) < 30);
            id_issue_rd_i = 5'($urandom_range(7));
            id_rs1_i      = 5'($urandom_range(7));
            id_rs2_i      = 5'($urandom_range(7));
            id_rd_i       = 5'($urandom_range(7));
            run_cycle();
        end
        chk("rand_busy", dut.u_sb.busy, busy_packed());

        // Asynchronous reset in mid-cycle with state built up.
        id_issue_i = 1'b1; id_issue_rd_i = 5'd12;
        ex_wen_i = 1'b1; ll_valid_i = 1'b1;
        run_cycle();
        #3 rst = 1'b1;
        #1;
        chk("arst_stall", 32'(ex_stall_o), 32'd0);
        chk("arst_wait",  32'(dut.wait_cnt), 32'd0);
        chk("arst_busy",  dut.u_sb.busy, 32'd0);
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        id_rs1_i = 5'd12;
        run_cycle();
        chk("arst_haz", 32'(o_haz), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
